// File: rtl/datapath_ctrl_pkg.sv
// Shared types and constants for the datapath sequencer: FSM states, instruction
// class codes, datapath select codes, instruction field positions and the decoded bundle.
package datapath_ctrl_pkg;

    localparam int INSTR_BITS = 20;

    localparam int CLASS_HI = 19;
    localparam int CLASS_LO = 16;
    localparam int WA_HI    = 15;
    localparam int WA_LO    = 12;
    localparam int RAA_HI   = 11;
    localparam int RAA_LO   = 8;
    localparam int RAB_HI   = 7;
    localparam int RAB_LO   = 4;
    localparam int IMM_HI   = 7;
    localparam int IMM_LO   = 0;
    localparam int OP_HI    = 2;
    localparam int OP_LO    = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        BR_WAIT,
        HALT
    } state_t;

    localparam logic [3:0] CL_NOP  = 4'h0;
    localparam logic [3:0] CL_ALU  = 4'h1;
    localparam logic [3:0] CL_LDI  = 4'h2;
    localparam logic [3:0] CL_IN   = 4'h3;
    localparam logic [3:0] CL_JMP  = 4'h5;
    localparam logic [3:0] CL_BRF  = 4'h6;
    localparam logic [3:0] CL_HALT = 4'h7;

    localparam logic [3:0] SEL_ALU = 4'h0;
    localparam logic [3:0] SEL_IMM = 4'h1;

    typedef struct packed {
        logic       wen;
        logic [3:0] sel;
        logic [7:0] ctrl;
        logic [3:0] wa;
        logic [3:0] raa;
        logic [3:0] rab;
        logic [2:0] op;
        logic       is_jmp;
        logic       is_brf;
        logic       is_halt;
        logic       illegal;
    } decoded_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder: maps the instruction register onto the
// datapath control bundle; fields an instruction class does not use stay zero.
module instr_decoder
    import datapath_ctrl_pkg::*;
#(
    parameter int INSTR_W = INSTR_BITS
) (
    input  logic [INSTR_W-1:0] ir,
    output decoded_t           dec
);

    logic [3:0] instrClass;

    assign instrClass = ir[CLASS_HI:CLASS_LO];

    always_comb begin
        dec = '0;
        case (instrClass)
            CL_NOP: dec = '0;
            CL_ALU: begin
                dec.wen = 1'b1;
                dec.sel = SEL_ALU;
                dec.wa  = ir[WA_HI:WA_LO];
                dec.raa = ir[RAA_HI:RAA_LO];
                dec.rab = ir[RAB_HI:RAB_LO];
                dec.op  = ir[OP_HI:OP_LO];
            end
            CL_LDI: begin
                dec.wen  = 1'b1;
                dec.sel  = SEL_IMM;
                dec.ctrl = ir[IMM_HI:IMM_LO];
                dec.wa   = ir[WA_HI:WA_LO];
            end
            CL_IN: begin
                dec.wen = 1'b1;
                dec.sel = ir[RAA_HI:RAA_LO];
                dec.wa  = ir[WA_HI:WA_LO];
            end
            CL_JMP:  dec.is_jmp = 1'b1;
            // Branch operands go to the ALU so Flag is valid in the following cycle
            CL_BRF: begin
                dec.is_brf = 1'b1;
                dec.raa    = ir[RAA_HI:RAA_LO];
                dec.rab    = ir[RAB_HI:RAB_LO];
                dec.op     = ir[OP_HI:OP_LO];
            end
            CL_HALT: dec.is_halt = 1'b1;
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Control unit in front of the datapath: fetches from a synchronous ROM, decodes and
// drives the datapath controls, resolving conditional branches from the ALU Flag.
module datapath_sequencer
    import datapath_ctrl_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [7:0]         Ctrl,
    output logic [3:0]         Sel,
    output logic               Wen,
    output logic [3:0]         WA,
    output logic [3:0]         RAA,
    output logic [3:0]         RAB,
    output logic [2:0]         Op,
    input  logic               Flag
);

    state_t             state;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic               errFlag;
    decoded_t           dec;
    logic [PC_W-1:0]    pcNext;
    logic [PC_W-1:0]    branchTarget;

    instr_decoder #(
        .INSTR_W(INSTR_W)
    ) u_decoder (
        .ir (ir),
        .dec(dec)
    );

    assign pcNext       = pc + PC_W'(1);
    assign branchTarget = PC_W'(ir[IMM_HI:IMM_LO]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= '0;
            ir      <= '0;
            errFlag <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state   <= FETCH;
                        pc      <= '0;
                        errFlag <= 1'b0;
                    end
                end
                FETCH:  state <= DECODE;
                DECODE: begin
                    ir    <= imem_rdata;
                    state <= EXEC;
                end
                EXEC: begin
                    if (dec.illegal) begin
                        errFlag <= 1'b1;
                        state   <= HALT;
                    end else if (dec.is_halt) begin
                        state <= HALT;
                    end else if (dec.is_brf) begin
                        state <= BR_WAIT;
                    end else if (dec.is_jmp) begin
                        pc    <= branchTarget;
                        state <= FETCH;
                    end else begin
                        pc    <= pcNext;
                        state <= FETCH;
                    end
                end
                // Taken branch replaces the increment, so pc moves exactly once
                BR_WAIT: begin
                    pc    <= Flag ? branchTarget : pcNext;
                    state <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Wen is masked by rst so a reset landing in EXEC never commits a register write
    always_comb begin
        Wen  = 1'b0;
        Sel  = SEL_ALU;
        Ctrl = '0;
        WA   = '0;
        RAA  = '0;
        RAB  = '0;
        Op   = '0;
        if (state == EXEC) begin
            Wen  = dec.wen & ~rst;
            Sel  = dec.sel;
            Ctrl = dec.ctrl;
            WA   = dec.wa;
            RAA  = dec.raa;
            RAB  = dec.rab;
            Op   = dec.op;
        end else if (state == BR_WAIT) begin
            RAA = dec.raa;
            RAB = dec.rab;
            Op  = dec.op;
        end
    end

    assign busy      = (state != IDLE) && (state != HALT);
    assign done      = (state == HALT);
    assign err       = errFlag;
    assign imem_addr = pc;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: ROM model, write-event scoreboard
// and one task per scenario with inline cycle-accurate checks.
module tb_datapath_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  imem_addr;
    logic [19:0] imem_rdata;
    logic [7:0]  Ctrl;
    logic [3:0]  Sel;
    logic        Wen;
    logic [3:0]  WA;
    logic [3:0]  RAA;
    logic [3:0]  RAB;
    logic [2:0]  Op;
    logic        Flag;

    typedef struct packed {
        logic [3:0] wa;
        logic [3:0] sel;
        logic [7:0] ctrl;
        logic [3:0] raa;
        logic [3:0] rab;
        logic [2:0] op;
    } wr_t;

    wr_t         expQ[$];
    wr_t         expWr;
    wr_t         gotWr;
    logic [19:0] rom[256];
    int          vectors = 0;
    int          miscompares = 0;

    datapath_sequencer #(
        .PC_W(8),
        .INSTR_W(20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .Ctrl      (Ctrl),
        .Sel       (Sel),
        .Wen       (Wen),
        .WA        (WA),
        .RAA       (RAA),
        .RAB       (RAB),
        .Op        (Op),
        .Flag      (Flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= rom[imem_addr];

    // Every Wen cycle must match the oldest outstanding expected write
    always @(negedge clk) begin
        if (Wen !== 1'b0) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_wen: Wen=%b WA=%h with no write expected", Wen, WA);
            end else begin
                expWr = expQ.pop_front();
                gotWr = {WA, Sel, Ctrl, RAA, RAB, Op};
                if (gotWr !== expWr) begin
                    miscompares++;
                    $display("[TB] FAIL write_event: got WA/Sel/Ctrl/RAA/RAB/Op=%h/%h/%h/%h/%h/%h expected %h/%h/%h/%h/%h/%h",
                             WA, Sel, Ctrl, RAA, RAB, Op,
                             expWr.wa, expWr.sel, expWr.ctrl, expWr.raa, expWr.rab, expWr.op);
                end
            end
        end
    end

    function automatic wr_t mkWr(input logic [3:0] wa, input logic [3:0] sel, input logic [7:0] ctrl,
                                 input logic [3:0] raa, input logic [3:0] rab, input logic [2:0] op);
        wr_t w;
        w = {wa, sel, ctrl, raa, rab, op};
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clearRom;
        for (int i = 0; i < 256; i++) rom[i] = 20'h0;
    endtask

    // Pulse start for one edge; returns during the first FETCH cycle
    task automatic pulseStart;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            tick;
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0 || Wen !== 1'b0 || imem_addr !== 8'h00 || err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_idle: cycle %0d busy=%b done=%b Wen=%b addr=%h err=%b expected 0/0/0/00/0",
                         i, busy, done, Wen, imem_addr, err);
            end
            tick;
        end
        vectors++;
        if ({Ctrl, Sel, WA, RAA, RAB, Op} !== 27'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: Ctrl/Sel/WA/RAA/RAB/Op=%h/%h/%h/%h/%h/%h expected all 0",
                     Ctrl, Sel, WA, RAA, RAB, Op);
        end
    endtask

    task automatic test_ldi_halt;
        clearRom;
        rom[0] = 20'h2305A;
        rom[1] = 20'h70000;
        expQ.push_back(mkWr(4'd3, 4'd1, 8'h5A, 4'd0, 4'd0, 3'd0));
        pulseStart;
        vectors++;
        if (imem_addr !== 8'h00 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ldi_fetch: addr=%h busy=%b expected 00/1", imem_addr, busy);
        end
        tick;
        tick;
        vectors++;
        if ({Wen, WA, Sel, Ctrl} !== {1'b1, 4'd3, 4'd1, 8'h5A}) begin
            miscompares++;
            $display("[TB] FAIL ldi_exec: Wen/WA/Sel/Ctrl=%b/%h/%h/%h expected 1/3/1/5a", Wen, WA, Sel, Ctrl);
        end
        tick;
        vectors++;
        if (imem_addr !== 8'h01 || Wen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ldi_next_fetch: addr=%h Wen=%b expected 01/0", imem_addr, Wen);
        end
        tick;
        tick;
        tick;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ldi_halt: done=%b busy=%b err=%b expected 1/0/0", done, busy, err);
        end
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL ldi_pending: %0d writes outstanding expected 0", expQ.size());
        end
    endtask

    task automatic test_alu;
        int cycles;
        clearRom;
        rom[0] = 20'h11245;
        rom[1] = 20'h70000;
        expQ.push_back(mkWr(4'd1, 4'd0, 8'h00, 4'd2, 4'd4, 3'd5));
        pulseStart;
        tick;
        tick;
        vectors++;
        if ({Wen, WA, RAA, RAB, Op, Sel} !== {1'b1, 4'd1, 4'd2, 4'd4, 3'd5, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL alu_exec: Wen/WA/RAA/RAB/Op/Sel=%b/%h/%h/%h/%h/%h expected 1/1/2/4/5/0",
                     Wen, WA, RAA, RAB, Op, Sel);
        end
        tick;
        vectors++;
        if (Wen !== 1'b0 || Op !== 3'd0 || RAA !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL alu_after_exec: Wen=%b Op=%h RAA=%h expected 0/0/0", Wen, Op, RAA);
        end
        waitDone(20, cycles);
        vectors++;
        if (done !== 1'b1 || expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL alu_done: done=%b pending=%0d expected 1/0", done, expQ.size());
        end
    endtask

    task automatic test_brf;
        int cycles;
        // Taken: Flag low during EXEC, high in BR_WAIT
        clearRom;
        rom[0]    = 20'h60110;
        rom[8'h10] = 20'h70000;
        Flag = 1'b0;
        pulseStart;
        tick;
        tick;
        vectors++;
        if ({Wen, RAA, RAB, Op} !== {1'b0, 4'd1, 4'd1, 3'd0}) begin
            miscompares++;
            $display("[TB] FAIL brf_taken_exec: Wen/RAA/RAB/Op=%b/%h/%h/%h expected 0/1/1/0", Wen, RAA, RAB, Op);
        end
        tick;
        vectors++;
        if ({Wen, RAA, RAB, Op, busy, imem_addr} !== {1'b0, 4'd1, 4'd1, 3'd0, 1'b1, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL brf_taken_wait: Wen/RAA/RAB/Op/busy/addr=%b/%h/%h/%h/%b/%h expected 0/1/1/0/1/00",
                     Wen, RAA, RAB, Op, busy, imem_addr);
        end
        Flag = 1'b1;
        tick;
        Flag = 1'b0;
        vectors++;
        if (imem_addr !== 8'h10 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL brf_taken_target: addr=%h busy=%b expected 10/1", imem_addr, busy);
        end
        waitDone(20, cycles);
        vectors++;
        if (done !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL brf_taken_done: done=%b err=%b expected 1/0", done, err);
        end

        // Not taken: Flag high during EXEC, low when sampled; target holds an illegal word
        clearRom;
        rom[0]     = 20'h62513;
        rom[1]     = 20'h70000;
        rom[8'h13] = 20'hC0000;
        pulseStart;
        tick;
        Flag = 1'b1;
        tick;
        vectors++;
        if ({Wen, RAA, RAB, Op} !== {1'b0, 4'd5, 4'd1, 3'd3}) begin
            miscompares++;
            $display("[TB] FAIL brf_nt_exec: Wen/RAA/RAB/Op=%b/%h/%h/%h expected 0/5/1/3", Wen, RAA, RAB, Op);
        end
        tick;
        Flag = 1'b0;
        vectors++;
        if ({RAA, RAB, Op, imem_addr} !== {4'd5, 4'd1, 3'd3, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL brf_nt_wait: RAA/RAB/Op/addr=%h/%h/%h/%h expected 5/1/3/00", RAA, RAB, Op, imem_addr);
        end
        tick;
        vectors++;
        if (imem_addr !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL brf_nt_next: addr=%h expected 01", imem_addr);
        end
        waitDone(20, cycles);
        vectors++;
        if (done !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL brf_nt_done: done=%b err=%b expected 1/0", done, err);
        end
    endtask

    task automatic test_jmp_wrap;
        clearRom;
        rom[0]     = 20'h500FF;
        rom[8'hFF] = 20'h00000;
        pulseStart;
        tick;
        tick;
        tick;
        vectors++;
        if (imem_addr !== 8'hFF) begin
            miscompares++;
            $display("[TB] FAIL jmp_target: addr=%h expected ff", imem_addr);
        end
        tick;
        tick;
        tick;
        vectors++;
        if (imem_addr !== 8'h00 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pc_wrap: addr=%h busy=%b expected 00/1", imem_addr, busy);
        end
        tick;
        // start during DECODE must be ignored
        pulseStart;
        tick;
        vectors++;
        if (imem_addr !== 8'hFF) begin
            miscompares++;
            $display("[TB] FAIL start_while_busy: addr=%h expected ff", imem_addr);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || imem_addr !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL jmp_reset: busy=%b addr=%h expected 0/00", busy, imem_addr);
        end
    endtask

    task automatic test_illegal;
        logic [3:0] badCls[4];
        int cycles;
        badCls = '{4'h4, 4'h8, 4'hC, 4'hF};
        for (int k = 0; k < 4; k++) begin
            clearRom;
            rom[0] = 20'h22011;
            rom[1] = {badCls[k], 16'h0000};
            expQ.push_back(mkWr(4'd2, 4'd1, 8'h11, 4'd0, 4'd0, 3'd0));
            pulseStart;
            vectors++;
            if (err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL err_clear_on_start: class %h err=%b expected 0", badCls[k], err);
            end
            waitDone(20, cycles);
            vectors++;
            if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || cycles != 6) begin
                miscompares++;
                $display("[TB] FAIL illegal_class: class %h done=%b err=%b busy=%b cycles=%0d expected 1/1/0/6",
                         badCls[k], done, err, busy, cycles);
            end
        end
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL illegal_pending: %0d writes outstanding expected 0", expQ.size());
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        vectors++;
        if (err !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_clear_on_reset: err=%b done=%b expected 0/0", err, done);
        end
    endtask

    task automatic test_back_to_back;
        int cycles;
        clearRom;
        rom[0] = 20'h2305A;
        rom[1] = 20'h11245;
        rom[2] = 20'h37900;
        rom[3] = 20'h70000;
        expQ.push_back(mkWr(4'd3, 4'd1, 8'h5A, 4'd0, 4'd0, 3'd0));
        expQ.push_back(mkWr(4'd1, 4'd0, 8'h00, 4'd2, 4'd4, 3'd5));
        expQ.push_back(mkWr(4'd7, 4'd9, 8'h00, 4'd0, 4'd0, 3'd0));
        pulseStart;
        waitDone(40, cycles);
        vectors++;
        if (cycles != 12 || done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_latency: cycles=%0d done=%b expected 12/1", cycles, done);
        end
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_pending: %0d writes outstanding expected 0", expQ.size());
        end
    endtask

    task automatic test_reset_mid;
        clearRom;
        rom[0] = 20'h2305A;
        rom[1] = 20'h70000;
        pulseStart;
        tick;
        tick;
        rst = 1'b1;
        #1;
        vectors++;
        if (Wen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_wen: Wen=%b expected 0", Wen);
        end
        tick;
        rst = 1'b0;
        vectors++;
        if ({busy, done, err, imem_addr, Wen, Sel, Ctrl, Op} !== 27'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_idle: busy/done/err/addr/Wen/Sel/Ctrl/Op=%b/%b/%b/%h/%b/%h/%h/%h expected all 0",
                     busy, done, err, imem_addr, Wen, Sel, Ctrl, Op);
        end
        rst = 1'b1;
        start = 1'b1;
        tick;
        rst = 1'b0;
        start = 1'b0;
        tick;
        vectors++;
        if (busy !== 1'b0 || imem_addr !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_beats_start: busy=%b addr=%h expected 0/00", busy, imem_addr);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        Flag  = 1'b0;
        clearRom;
        test_reset;
        test_ldi_halt;
        test_alu;
        test_brf;
        test_jmp_wrap;
        test_illegal;
        test_back_to_back;
        test_reset_mid;
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
